// File: rtl/fifo_sync_lvl.sv
// fifo_sync_lvl: single-clock FIFO with occupancy level, watermark flags and sticky error flags.
// Define FIFO_SYNC_LVL_FWFT_EN for first-word-fall-through output; the default is a registered read.
module fifo_sync_lvl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_BITS    = 4,
  parameter int AFULL_LEVEL  = (1 << ADDR_BITS) - 2,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_BITS:0]    level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] AF_LVL = (ADDR_BITS+1)'(AFULL_LEVEL);
  localparam logic [ADDR_BITS:0] AE_LVL = (ADDR_BITS+1)'(AEMPTY_LEVEL);

  logic [ADDR_BITS:0]    wptr_q, wptr_d;
  logic [ADDR_BITS:0]    rptr_q, rptr_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Status is decoded purely from registered pointers, so no input reaches any flag combinationally.
  assign level        = wptr_q - rptr_q;
  assign fifo_empty   = (wptr_q == rptr_q);
  assign fifo_full    = (wptr_q[ADDR_BITS] != rptr_q[ADDR_BITS]) &&
                        (wptr_q[ADDR_BITS-1:0] == rptr_q[ADDR_BITS-1:0]);
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  assign wr_acc = w_en && !fifo_full;
  assign rd_acc = r_en && !fifo_empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) rptr_d = rptr_q + 1'b1;
    // A new error in the same cycle as err_clr must survive the clear.
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (w_en && fifo_full)  ovf_d = 1'b1;
    if (r_en && fifo_empty) udf_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wptr_q[ADDR_BITS-1:0]] <= data_in;
  end

`ifdef FIFO_SYNC_LVL_FWFT_EN
  assign data_out = fifo_empty ? '0 : mem[rptr_q[ADDR_BITS-1:0]];
`else
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (rd_acc) dout_d = mem[rptr_q[ADDR_BITS-1:0]];
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) dout_q <= '0;
    else           dout_q <= dout_d;
  end

  assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_fifo_sync_lvl.sv
// Directed bench for fifo_sync_lvl: vector table for fill/drain/flags plus hand-written corner sequences.
module tb_fifo_sync_lvl;

`ifdef FIFO_SYNC_LVL_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        resetn_i = 1'b0;
  logic [31:0] data_in = '0;
  logic        w_en = 1'b0, r_en = 1'b0, err_clr = 1'b0;
  logic [31:0] data_out;
  logic        fifo_empty, fifo_full, almost_full, almost_empty;
  logic [4:0]  level;
  logic        overflow, underflow;

  int total = 0;
  int bad   = 0;

  fifo_sync_lvl #(.DATA_WIDTH(32), .ADDR_BITS(4), .AFULL_LEVEL(14), .AEMPTY_LEVEL(2)) dut (
    .clk_i(clk_i), .resetn_i(resetn_i), .data_in(data_in), .w_en(w_en), .r_en(r_en),
    .err_clr(err_clr), .data_out(data_out), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        w, r, c;
    logic [31:0] din;
    logic [31:0] dout;
    logic [4:0]  lvl;
    logic        emp, ful, af, ae, ovf, udf;
  } vec_t;

  vec_t tv[$];

  // Reference model: a queue of stored words plus the registered read word and error flags.
  logic [31:0] q[$];
  logic [31:0] m_dout;
  logic        m_ovf, m_udf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic cyc(input logic w, input logic r, input logic c, input logic [31:0] d);
    bit wacc, racc;
    w_en = w; r_en = r; err_clr = c; data_in = d;
    wacc = w && (q.size() < 16);
    racc = r && (q.size() > 0);
    @(posedge clk_i);
    #1;
    if (c) begin m_ovf = 1'b0; m_udf = 1'b0; end
    if (w && !wacc) m_ovf = 1'b1;
    if (r && !racc) m_udf = 1'b1;
    if (racc) m_dout = q.pop_front();
    if (wacc) q.push_back(d);
    w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0;
  endtask

  function automatic logic [31:0] exp_dout();
    if (!FWFT) return m_dout;
    return (q.size() > 0) ? q[0] : 32'h0;
  endfunction

  task automatic check_model(input string tag);
    check({tag, " data_out"}, data_out, exp_dout());
    check({tag, " level"}, 32'(level), 32'(q.size()));
    check({tag, " empty"}, 32'(fifo_empty), 32'(q.size() == 0));
    check({tag, " full"}, 32'(fifo_full), 32'(q.size() == 16));
    check({tag, " afull"}, 32'(almost_full), 32'(q.size() >= 14));
    check({tag, " aempty"}, 32'(almost_empty), 32'(q.size() <= 2));
    check({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, " underflow"}, 32'(underflow), 32'(m_udf));
  endtask

  task automatic do_reset();
    resetn_i = 1'b0;
    w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    resetn_i = 1'b1;
    model_reset();
  endtask

  function automatic vec_t mk(input logic w, r, c, input logic [31:0] din, dout,
                              input int lvl, input logic ovf, udf);
    vec_t v;
    v.w = w; v.r = r; v.c = c; v.din = din; v.dout = dout; v.lvl = 5'(lvl);
    v.emp = (lvl == 0); v.ful = (lvl == 16); v.af = (lvl >= 14); v.ae = (lvl <= 2);
    v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  initial begin
    // Hand-computed table: fill 0x00..0x0F, overflow, clear, drain, underflow, clear-vs-set.
    for (int i = 0; i < 16; i++) tv.push_back(mk(1, 0, 0, 32'(i), 32'h0, i + 1, 0, 0));
    tv.push_back(mk(1, 0, 0, 32'h55, 32'h0, 16, 1, 0));
    tv.push_back(mk(0, 0, 1, 32'h0, 32'h0, 16, 0, 0));
    for (int j = 0; j < 16; j++)
      tv.push_back(mk(0, 1, 0, 32'h0, FWFT ? ((j == 15) ? 32'h0 : 32'(j + 1)) : 32'(j), 15 - j, 0, 0));
    tv.push_back(mk(0, 1, 0, 32'h0, FWFT ? 32'h0 : 32'h0F, 0, 0, 1));
    tv.push_back(mk(0, 1, 1, 32'h0, FWFT ? 32'h0 : 32'h0F, 0, 0, 1));
    tv.push_back(mk(0, 0, 1, 32'h0, FWFT ? 32'h0 : 32'h0F, 0, 0, 0));

    do_reset();
    check("reset data_out", data_out, 32'h0);
    check("reset level", 32'(level), 32'h0);
    check("reset empty", 32'(fifo_empty), 32'h1);
    check("reset full", 32'(fifo_full), 32'h0);
    check("reset aempty", 32'(almost_empty), 32'h1);
    check("reset afull", 32'(almost_full), 32'h0);
    check("reset overflow", 32'(overflow), 32'h0);
    check("reset underflow", 32'(underflow), 32'h0);

    foreach (tv[k]) begin
      cyc(tv[k].w, tv[k].r, tv[k].c, tv[k].din);
      check($sformatf("row%0d data_out", k), data_out, tv[k].dout);
      check($sformatf("row%0d level", k), 32'(level), 32'(tv[k].lvl));
      check($sformatf("row%0d empty", k), 32'(fifo_empty), 32'(tv[k].emp));
      check($sformatf("row%0d full", k), 32'(fifo_full), 32'(tv[k].ful));
      check($sformatf("row%0d afull", k), 32'(almost_full), 32'(tv[k].af));
      check($sformatf("row%0d aempty", k), 32'(almost_empty), 32'(tv[k].ae));
      check($sformatf("row%0d overflow", k), 32'(overflow), 32'(tv[k].ovf));
      check($sformatf("row%0d underflow", k), 32'(underflow), 32'(tv[k].udf));
    end

    // Pointer wrap: fill 10 / drain 10 twice, starting from pointers already wrapped once.
    for (int rnd = 0; rnd < 2; rnd++) begin
      for (int k = 0; k < 10; k++) begin
        cyc(1, 0, 0, 32'h300 + 32'(rnd * 10 + k));
        check_model($sformatf("wrap w%0d.%0d", rnd, k));
      end
      for (int k = 0; k < 10; k++) begin
        cyc(0, 1, 0, 32'h0);
        check_model($sformatf("wrap r%0d.%0d", rnd, k));
      end
    end

    // Steady-state simultaneous write and read at level 5.
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 32'h400 + 32'(k));
    check_model("sim pre");
    for (int k = 0; k < 20; k++) begin
      cyc(1, 1, 0, 32'h405 + 32'(k));
      check_model($sformatf("sim %0d", k));
      check($sformatf("sim lvl%0d", k), 32'(level), 32'd5);
    end
    for (int k = 0; k < 5; k++) cyc(0, 1, 0, 32'h0);
    check_model("sim drain");

    // Simultaneous write and read on a full FIFO, then err_clr.
    do_reset();
    for (int k = 0; k < 16; k++) cyc(1, 0, 0, 32'h500 + 32'(k));
    check_model("full pre");
    cyc(1, 1, 0, 32'h999);
    check("fullrw level", 32'(level), 32'd15);
    check("fullrw overflow", 32'(overflow), 32'h1);
    check("fullrw data_out", data_out, FWFT ? 32'h501 : 32'h500);
    check_model("fullrw");
    cyc(0, 0, 1, 32'h0);
    check("fullrw clr overflow", 32'(overflow), 32'h0);
    check_model("fullrw clr");

    // Asynchronous reset mid-fill at level 7.
    do_reset();
    for (int k = 0; k < 7; k++) cyc(1, 0, 0, 32'h600 + 32'(k));
    check("midrst pre level", 32'(level), 32'd7);
    #2 resetn_i = 1'b0;
    #1;
    check("midrst level", 32'(level), 32'd0);
    check("midrst empty", 32'(fifo_empty), 32'h1);
    check("midrst data_out", data_out, 32'h0);
    #2 resetn_i = 1'b1;
    model_reset();
    cyc(1, 0, 0, 32'h777);
    check("midrst first write level", 32'(level), 32'd1);
    check_model("midrst post");

`ifdef FIFO_SYNC_LVL_FWFT_EN
    do_reset();
    cyc(1, 0, 0, 32'hA5);
    check("fwft head", data_out, 32'hA5);
    cyc(0, 1, 0, 32'h0);
    check("fwft pop data_out", data_out, 32'h0);
    check("fwft pop empty", 32'(fifo_empty), 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
